perf_enc_stall_det: RTL and testbench
=====================================

# perf_enc_stall_det

Per-cycle stall detector that sits directly upstream of the encryption-stall performance counter in the OR1200 data path. It watches the LSU-to-data-memory handshake (through the encryption engine) and tracks each outstanding load or store. For every cycle a transaction waits beyond the baseline unencrypted ack latency, it emits a one-cycle `delayed_ack_load` or `delayed_ack_store` flag. It also reports the total latency of each completed transaction for SPR readout.

## Interface
Parameters:
- `BASE_LAT`, default 2: cycle index at which an unencrypted access normally acks. Legal range 1..254.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `en`  in  1  enable for the stall flags; the FSM tracks transactions regardless of `en`
- `dcpu_cycstb`  in  1  data request (cyc & stb), held until ack, err or flush
- `dcpu_we`  in  1  1 = store, 0 = load; sampled in the first cycle of a transaction only
- `dcpu_ack`  in  1  transaction completes in this cycle
- `dcpu_err`  in  1  bus error; terminates the transaction in this cycle
- `delayed_ack_load`  out  1  previous cycle was a load stall cycle
- `delayed_ack_store`  out  1  previous cycle was a store stall cycle
- `last_lat`  out  8  latency of the most recent acked transaction, saturating at 255
- `last_lat_we`  out  1  type of that transaction (1 = store)
- `lat_valid`  out  1  one-cycle pulse: `last_lat` and `last_lat_we` were updated in the previous cycle
- `err_abort`  out  1  one-cycle pulse: a transaction ended on `dcpu_err` in the previous cycle

## Operation
- FSM states:
  - IDLE: no transaction outstanding.
  - LOAD: a load is outstanding.
  - STORE: a store is outstanding.
- Cycle index k of a transaction:
  - In IDLE with `dcpu_cycstb` high, k = 1.
  - In LOAD or STORE, k = `wcnt` + 1, where `wcnt` is an 8-bit register.
  - k saturates at 255.
- IDLE transitions, when `dcpu_cycstb` is high:
  - `dcpu_ack` or `dcpu_err` in the same cycle: the transaction completes in that cycle and the FSM stays in IDLE.
  - Otherwise: go to LOAD or STORE according to `dcpu_we`, and set `wcnt` to 1.
- LOAD/STORE transitions:
  - `dcpu_ack` or `dcpu_err` high: return to IDLE.
  - `dcpu_cycstb` low with no ack or err (pipeline flush): return to IDLE silently, with no flags and no latency capture.
  - Otherwise: stay, and `wcnt` ← min(`wcnt` + 1, 255).
- Stall cycle: a cycle with a transaction active, `dcpu_ack` = 0, `dcpu_err` = 0 and k ≥ `BASE_LAT`.
  - When `en` = 1, the next cycle asserts `delayed_ack_load` or `delayed_ack_store` according to the latched type.
  - The two flags are never high together.
- Stall count for a transaction acked at cycle k_ack is max(0, k_ack − `BASE_LAT`).
- Ack completion:
  - `last_lat` ← k_ack, saturating at 255.
  - `last_lat_we` ← type.
  - `lat_valid` pulses for one cycle.
- Err completion: `err_abort` pulses for one cycle; `last_lat` is unchanged.
- Simultaneous `dcpu_ack` and `dcpu_err`: treated as err.
- `dcpu_we` changing mid-transaction is ignored.
- Saturation: once k = 255, every further waiting cycle is still a stall cycle.
- `en` low mid-transaction: flags for those cycles are suppressed. Tracking and latency capture continue.

## Timing
- Every output resets to 0, and the FSM resets to IDLE with `wcnt` = 0.
- All outputs are registered. Each output reflects the events of the preceding cycle (latency 1).
- Back-to-back transactions:
  - The ack cycle of one transaction returns the FSM to IDLE.
  - If `dcpu_cycstb` is high in the following cycle, that cycle is k = 1 of a new transaction.
  - There are no dead cycles between transactions.
- Reset asserted mid-transaction: all state and outputs clear immediately (asynchronous). Nothing is flagged for the aborted transaction.

## Test plan
1. `BASE_LAT`=2, load with ack at k=5, `en`=1 → `delayed_ack_load` high for exactly the 3 cycles following k=2,3,4; `last_lat`=5, `last_lat_we`=0, `lat_valid` pulses the cycle after the ack.
2. Zero-wait store (ack at k=1), then a store acked at k=2 → no `delayed_ack_store` at all; `lat_valid` pulses twice, with `last_lat`=1 then 2.
3. Back-to-back load (ack k=4) then store (ack k=3) → load flags for 2 cycles, then store flags for 1 cycle; flags are never simultaneous; `last_lat` goes 4 then 3.
4. Load held 300 cycles, then ack → 298 flag cycles; `last_lat`=255.
5. Store with `dcpu_err` at k=6 → 4 store flags, then an `err_abort` pulse; `last_lat` unchanged. Load with `dcpu_cycstb` dropped at k=4 → 2 flags, no pulses, FSM back in IDLE.
6. Load outstanding with `en` low for k=3..4, ack at k=6 → flags only for k=2 and k=5; `last_lat`=6. Separately, `rst` asserted at k=3 → all outputs 0 immediately, and the next request starts at k=1.

Source files
------------

// File: rtl/perf_enc_stall_det.sv
// Per-cycle stall detector for encrypted data-memory accesses: flags every cycle a
// load/store waits past the unencrypted ack latency and captures completed latencies.
module perf_enc_stall_det #(
    parameter int BASE_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       dcpu_cycstb,
    input  logic       dcpu_we,
    input  logic       dcpu_ack,
    input  logic       dcpu_err,
    output logic       delayed_ack_load,
    output logic       delayed_ack_store,
    output logic [7:0] last_lat,
    output logic       last_lat_we,
    output logic       lat_valid,
    output logic       err_abort
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STORE
    } state_t;

    localparam logic [7:0] LP_BASE_LAT = 8'(BASE_LAT);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_wcnt;
    logic [7:0] w_wcnt_nxt;

    logic       w_busy;
    logic       w_done;
    logic       w_active;
    logic       w_type;
    logic [7:0] w_k;
    logic       w_stall;
    logic       w_ack_done;
    logic       w_err_done;

    logic       r_dal;
    logic       r_das;
    logic [7:0] r_last_lat;
    logic       r_last_we;
    logic       r_lat_valid;
    logic       r_err_abort;

    // A flush cycle (request dropped while busy, no ack/err) is not an active cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        w_state_nxt = ST_IDLE;
        w_wcnt_nxt  = 8'd0;

        w_busy     = (r_state != ST_IDLE);
        w_done     = dcpu_ack | dcpu_err;
        w_active   = w_busy ? (dcpu_cycstb | w_done) : dcpu_cycstb;
        w_type     = w_busy ? (r_state == ST_STORE) : dcpu_we;
        w_k        = !w_busy ? 8'd1 : ((r_wcnt == 8'd255) ? 8'd255 : r_wcnt + 8'd1);
        w_stall    = w_active & ~w_done & (w_k >= LP_BASE_LAT);
        w_ack_done = w_active & dcpu_ack & ~dcpu_err;
        w_err_done = w_active & dcpu_err;

        // Next wcnt is simply this cycle's saturated index k.
        if (w_active && !w_done) begin
            w_state_nxt = w_type ? ST_STORE : ST_LOAD;
            w_wcnt_nxt  = w_k;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_wcnt  <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dal       <= 1'b0;
            r_das       <= 1'b0;
            r_last_lat  <= 8'd0;
            r_last_we   <= 1'b0;
            r_lat_valid <= 1'b0;
            r_err_abort <= 1'b0;
        end else begin
            r_dal       <= w_stall & en & ~w_type;
            r_das       <= w_stall & en & w_type;
            r_lat_valid <= w_ack_done;
            r_err_abort <= w_err_done;
            if (w_ack_done) begin
                r_last_lat <= w_k;
                r_last_we  <= w_type;
            end
        end
    end

    assign delayed_ack_load  = r_dal;
    assign delayed_ack_store = r_das;
    assign last_lat          = r_last_lat;
    assign last_lat_we       = r_last_we;
    assign lat_valid         = r_lat_valid;
    assign err_abort         = r_err_abort;

endmodule

// File: tb/tb_perf_enc_stall_det.sv
// Self-checking bench for perf_enc_stall_det: fixed vector table, directed
// multi-cycle sequences and random traffic against a transaction-level model.
module tb_perf_enc_stall_det;

    localparam int LP_BASE_LAT = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       dcpu_cycstb;
    logic       dcpu_we;
    logic       dcpu_ack;
    logic       dcpu_err;
    logic       delayed_ack_load;
    logic       delayed_ack_store;
    logic [7:0] last_lat;
    logic       last_lat_we;
    logic       lat_valid;
    logic       err_abort;

    perf_enc_stall_det #(.BASE_LAT(LP_BASE_LAT)) dut (
        .clk               (clk),
        .rst               (rst),
        .en                (en),
        .dcpu_cycstb       (dcpu_cycstb),
        .dcpu_we           (dcpu_we),
        .dcpu_ack          (dcpu_ack),
        .dcpu_err          (dcpu_err),
        .delayed_ack_load  (delayed_ack_load),
        .delayed_ack_store (delayed_ack_store),
        .last_lat          (last_lat),
        .last_lat_we       (last_lat_we),
        .lat_valid         (lat_valid),
        .err_abort         (err_abort)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int n_dal   = 0;
    int n_das   = 0;
    int n_lv    = 0;
    int n_ea    = 0;

    // Transaction-level model: a request is either outstanding or not, and we
    // only remember how many cycles it has been waiting so far.
    bit m_busy;
    int m_waited;
    bit m_type;
    int m_last_lat;
    bit m_last_we;

    // Output vector: {dal, das, lat_valid, err_abort, last_lat_we, last_lat[7:0]}
    function automatic logic [12:0] pack_dut();
        return {delayed_ack_load, delayed_ack_store, lat_valid, err_abort,
                last_lat_we, last_lat};
    endfunction

    task automatic model_reset();
        m_busy     = 1'b0;
        m_waited   = 0;
        m_type     = 1'b0;
        m_last_lat = 0;
        m_last_we  = 1'b0;
    endtask

    function automatic logic [12:0] model_step(input bit cs, we, ack, err, en_i);
        bit act, typ, stall, lv, ea;
        int k;
        act   = m_busy ? (cs || ack || err) : cs;
        typ   = m_busy ? m_type : we;
        k     = (m_waited + 1 > 255) ? 255 : m_waited + 1;
        stall = act && !ack && !err && (k >= LP_BASE_LAT);
        lv    = act && ack && !err;
        ea    = act && err;
        if (lv) begin
            m_last_lat = k;
            m_last_we  = typ;
        end
        if (act && !ack && !err) begin
            m_busy   = 1'b1;
            m_type   = typ;
            m_waited = m_waited + 1;
        end else begin
            m_busy   = 1'b0;
            m_waited = 0;
        end
        return {stall && en_i && !typ, stall && en_i && typ, lv, ea, m_last_we,
                8'(m_last_lat)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit cs, we, ack, err, en_i);
        dcpu_cycstb = cs;
        dcpu_we     = we;
        dcpu_ack    = ack;
        dcpu_err    = err;
        en          = en_i;
    endtask

    task automatic count_outputs();
        if (delayed_ack_load)  n_dal++;
        if (delayed_ack_store) n_das++;
        if (lat_valid)         n_lv++;
        if (err_abort)         n_ea++;
    endtask

    // One clock: inputs applied at the falling edge, outputs sampled 1 after the rising edge.
    task automatic tick(input bit cs, we, ack, err, en_i, input string name);
        logic [12:0] exp;
        drive(cs, we, ack, err, en_i);
        exp = model_step(cs, we, ack, err, en_i);
        @(posedge clk);
        #1;
        check(name, 32'(pack_dut()), 32'(exp));
        count_outputs();
        @(negedge clk);
    endtask

    task automatic clear_counts();
        n_dal = 0;
        n_das = 0;
        n_lv  = 0;
        n_ea  = 0;
    endtask

    typedef struct {
        bit          cs, we, ack, err, en_i;
        logic [12:0] exp;
    } vec_t;

    vec_t vecs[12];

    initial begin
        // Load acked at k=5 (3 stall flags), then zero-wait store and k=2 store.
        vecs[0]  = '{1, 0, 0, 0, 1, {5'b00000, 8'd0}};
        vecs[1]  = '{1, 0, 0, 0, 1, {5'b10000, 8'd0}};
        vecs[2]  = '{1, 0, 0, 0, 1, {5'b10000, 8'd0}};
        vecs[3]  = '{1, 0, 0, 0, 1, {5'b10000, 8'd0}};
        vecs[4]  = '{1, 1, 1, 0, 1, {5'b00100, 8'd5}};
        vecs[5]  = '{0, 0, 0, 0, 1, {5'b00000, 8'd5}};
        vecs[6]  = '{1, 1, 1, 0, 1, {5'b00101, 8'd1}};
        vecs[7]  = '{1, 1, 0, 0, 1, {5'b00001, 8'd1}};
        vecs[8]  = '{1, 0, 1, 0, 1, {5'b00101, 8'd2}};
        vecs[9]  = '{0, 0, 0, 0, 1, {5'b00001, 8'd2}};
        vecs[10] = '{0, 0, 1, 1, 1, {5'b00001, 8'd2}};
        vecs[11] = '{0, 1, 0, 0, 1, {5'b00001, 8'd2}};

        drive(0, 0, 0, 0, 1);
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_outputs", 32'(pack_dut()), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            logic [12:0] ignore;
            drive(vecs[i].cs, vecs[i].we, vecs[i].ack, vecs[i].err, vecs[i].en_i);
            ignore = model_step(vecs[i].cs, vecs[i].we, vecs[i].ack, vecs[i].err, vecs[i].en_i);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), 32'(pack_dut()), 32'(vecs[i].exp));
            @(negedge clk);
        end

        // Back-to-back load (ack k=4) then store (ack k=3).
        clear_counts();
        for (int k = 1; k <= 3; k++) tick(1, 0, 0, 0, 1, "b2b_load_wait");
        tick(1, 0, 1, 0, 1, "b2b_load_ack");
        check("b2b_load_lat", 32'(last_lat), 32'd4);
        for (int k = 1; k <= 2; k++) tick(1, 1, 0, 0, 1, "b2b_store_wait");
        tick(1, 1, 1, 0, 1, "b2b_store_ack");
        tick(0, 0, 0, 0, 1, "b2b_idle");
        check("b2b_load_flags", 32'(n_dal), 32'd2);
        check("b2b_store_flags", 32'(n_das), 32'd1);
        check("b2b_store_lat", 32'(last_lat), 32'd3);

        // Load held 300 cycles, latency saturates.
        clear_counts();
        for (int k = 1; k < 300; k++) tick(1, 0, 0, 0, 1, "sat_wait");
        tick(1, 0, 1, 0, 1, "sat_ack");
        tick(0, 0, 0, 0, 1, "sat_idle");
        check("sat_flags", 32'(n_dal), 32'd298);
        check("sat_lat", 32'(last_lat), 32'd255);

        // Store errored at k=6, with dcpu_we toggled mid-transaction.
        clear_counts();
        for (int k = 1; k <= 5; k++) tick(1, (k == 1) ? 1'b1 : 1'b0, 0, 0, 1, "err_wait");
        tick(1, 0, 1, 1, 1, "err_end");
        tick(0, 0, 0, 0, 1, "err_idle");
        check("err_flags", 32'(n_das), 32'd4);
        check("err_pulse", 32'(n_ea), 32'd1);
        check("err_no_lv", 32'(n_lv), 32'd0);
        check("err_lat_kept", 32'(last_lat), 32'd255);

        // Load flushed at k=4.
        clear_counts();
        for (int k = 1; k <= 3; k++) tick(1, 0, 0, 0, 1, "flush_wait");
        tick(0, 0, 0, 0, 1, "flush_drop");
        tick(0, 0, 0, 0, 1, "flush_idle");
        check("flush_flags", 32'(n_dal), 32'd2);
        check("flush_pulses", 32'(n_lv + n_ea), 32'd0);
        tick(1, 1, 1, 0, 1, "flush_next_k1");
        check("flush_next_lat", 32'(last_lat), 32'd1);

        // en low for k=3..4, ack at k=6.
        clear_counts();
        for (int k = 1; k <= 5; k++) tick(1, 0, 0, 0, (k == 3 || k == 4) ? 1'b0 : 1'b1, "en_wait");
        tick(1, 0, 1, 0, 1, "en_ack");
        check("en_flags", 32'(n_dal), 32'd2);
        check("en_lat", 32'(last_lat), 32'd6);

        // Asynchronous reset mid-transaction at k=3.
        tick(1, 0, 0, 0, 1, "rst_k1");
        tick(1, 0, 0, 0, 1, "rst_k2");
        check("rst_pre_flag", 32'(delayed_ack_load), 32'd1);
        drive(1, 0, 0, 0, 1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_clear", 32'(pack_dut()), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 1);
        @(negedge clk);
        tick(1, 0, 1, 0, 1, "rst_next_k1");
        check("rst_next_lat", 32'(last_lat), 32'd1);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 4) == 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 7) != 0, "random");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
